color_select_ctrl: RTL
======================

# color_select_ctrl

Player-side initiator for the color-change and new-game handshakes served by the flood-fill engine. It debounces the four board buttons and moves a color cursor. It launches one flood request per select press and holds off further requests until the engine finishes. It also counts moves against a limit. It sits between the button inputs and the flood-fill engine, and its cursor and move count also feed the display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a button level is accepted (raise for silicon; keep small for simulation).
- MAX_MOVES, 25: move limit; range 1..63.

Ports:
- CLOCK  in  1  system clock; everything is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BTN_LEFT, BTN_RIGHT, BTN_SELECT, BTN_NEW  in  1 each  raw, asynchronous button levels.
- COLOR_NUM  in  4  colors in play; values below 2 are treated as 2, values above 8 as 8.
- CURSOR_COLOR  out  3  highlighted color index.
- COLOR_SELECTED  out  3  color sent to the engine; stable from SIG assertion until the move completes.
- COLOR_SEL_SIG  out  1  color-change request.
- CHANGING_COLOR  in  1  engine busy/acknowledge.
- START_NEW_GAME  out  1  new-game request.
- STARTED_GAME  in  1  engine new-game acknowledge.
- MOVE_COUNT  out  6  completed moves since the last new game.
- OUT_OF_MOVES  out  1  high when MOVE_COUNT >= MAX_MOVES.
- GAME_ACTIVE  out  1  high once a new-game handshake has completed.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Button conditioning, per button:
  - Two-flop synchronizer, then a stability counter.
  - A synchronized level that differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles replaces the debounced level.
  - Any sample that matches the debounced level clears the counter.
  - A debounced 0→1 transition produces a one-cycle press pulse. Release produces nothing.
- Cursor:
  - LEFT decrements CURSOR_COLOR and RIGHT increments it, wrapping within 0..N-1, where N is the clamped COLOR_NUM.
  - LEFT and RIGHT pulses in the same cycle leave the cursor unchanged.
  - If CURSOR_COLOR >= N (COLOR_NUM lowered), the cursor is forced to 0 on the next cycle.
  - The cursor is updated in every state.
- FSM states: IDLE, NG_REQ, NG_REL, SEL_REQ, SEL_WAIT.
  - IDLE, pending new game (NEW pulse, or the pending flag set): go to NG_REQ and clear the pending flag. This has priority over select.
  - IDLE, SELECT pulse with GAME_ACTIVE=1 and OUT_OF_MOVES=0: COLOR_SELECTED<=CURSOR_COLOR, go to SEL_REQ. Otherwise the select is discarded.
  - NG_REQ: START_NEW_GAME=1. When STARTED_GAME=1, go to NG_REL; on that transition MOVE_COUNT<=0 and GAME_ACTIVE<=1.
  - NG_REL: START_NEW_GAME=0. When STARTED_GAME=0, go to IDLE.
  - SEL_REQ: COLOR_SEL_SIG=1. When CHANGING_COLOR=1, go to SEL_WAIT.
  - SEL_WAIT: COLOR_SEL_SIG=0. When CHANGING_COLOR=0, MOVE_COUNT increments (saturating at 63) and the FSM goes to IDLE.
- NEW pulse outside IDLE: sets the pending flag, and the request is serviced on return to IDLE. SELECT pulses outside IDLE are dropped.
- Every move that completes is counted, including a move that selects the color already at the origin.
- Outputs are registered, except BUSY and OUT_OF_MOVES, which are decoded from registers.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; pending flag, debounced levels and counters are 0.
  - The reset is asynchronous at assertion and takes effect mid-handshake: requests drop immediately, with no wait for the engine.
- Press latency: a raw rising level that is stable before CLOCK edge k produces a press pulse on cycle k+2+DEBOUNCE_CYCLES.
- Select handshake:
  - COLOR_SEL_SIG rises the cycle after the SELECT pulse.
  - It falls the cycle after CHANGING_COLOR is first sampled high.
  - MOVE_COUNT updates the cycle after CHANGING_COLOR is sampled low in SEL_WAIT.
- COLOR_SEL_SIG is never high while the FSM is in SEL_WAIT. This keeps the engine from retriggering when it drops CHANGING_COLOR.
- New-game handshake: START_NEW_GAME is held until STARTED_GAME is sampled high, then released. A new request cannot begin until STARTED_GAME has been seen low.
- An engine that never acknowledges leaves the FSM waiting indefinitely; RESET is the only exit.

## Test plan
- DEBOUNCE_CYCLES=4; SELECT bounces 1,0,1,0 on alternate cycles, then holds 1 → no pulse during the bounce; exactly one pulse 6 cycles after the stable hold begins.
- COLOR_NUM=6, cursor 5, RIGHT → 0; LEFT from 0 → 5; COLOR_NUM dropped to 3 with cursor 5 → cursor 0 next cycle.
- Before any new game, SELECT → no COLOR_SEL_SIG. NEW with STARTED_GAME echoed after 3 cycles → START_NEW_GAME high for exactly those cycles, then GAME_ACTIVE=1 and MOVE_COUNT=0.
- Cursor 3, SELECT, engine raises CHANGING_COLOR 1 cycle later and holds it 20 cycles → COLOR_SELECTED=3, COLOR_SEL_SIG high 2 cycles, MOVE_COUNT 0→1 after the drop, second SELECT mid-move dropped.
- MAX_MOVES=2: two completed moves → OUT_OF_MOVES=1, third SELECT ignored. NEW pressed during a move → NG_REQ entered immediately after SEL_WAIT exits and MOVE_COUNT resets to 0.
- RESET asserted in SEL_REQ → COLOR_SEL_SIG low in the same cycle without waiting for a clock edge, and all outputs at 0.

Source files
------------

// File: rtl/color_select_ctrl.sv
// Player-side controller: debounces the board buttons, moves the color cursor, and drives the
// color-change and new-game handshakes toward the flood-fill engine while counting moves.
module color_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_MOVES       = 25
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_SELECT,
    input  logic       BTN_NEW,
    input  logic [3:0] COLOR_NUM,
    output logic [2:0] CURSOR_COLOR,
    output logic [2:0] COLOR_SELECTED,
    output logic       COLOR_SEL_SIG,
    input  logic       CHANGING_COLOR,
    output logic       START_NEW_GAME,
    input  logic       STARTED_GAME,
    output logic [5:0] MOVE_COUNT,
    output logic       OUT_OF_MOVES,
    output logic       GAME_ACTIVE,
    output logic       BUSY
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StNgReq,
        StNgRel,
        StSelReq,
        StSelWait
    } state_t;

    // Button bit order: 0 left, 1 right, 2 select, 3 new.
    logic [3:0]            btn_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d, deb_dly_q;
    logic [3:0]            press_q;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    logic       press_left, press_right, press_sel, press_new;
    logic [3:0] color_n;
    logic [2:0] cursor_d;

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [2:0] color_sel_d;
    logic [5:0] move_d;
    logic       active_d;
    logic       sel_sig_d;
    logic       start_d;

    assign btn_raw     = {BTN_NEW, BTN_SELECT, BTN_RIGHT, BTN_LEFT};
    assign press_left  = press_q[0];
    assign press_right = press_q[1];
    assign press_sel   = press_q[2];
    assign press_new   = press_q[3];

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        if (COLOR_NUM < 4'd2) begin
            color_n = 4'd2;
        end else if (COLOR_NUM > 4'd8) begin
            color_n = 4'd8;
        end else begin
            color_n = COLOR_NUM;
        end
    end

    always_comb begin
        cursor_d = CURSOR_COLOR;
        if ({1'b0, CURSOR_COLOR} >= color_n) begin
            // Palette shrank under the cursor.
            cursor_d = '0;
        end else if (press_left && !press_right) begin
            cursor_d = (CURSOR_COLOR == 3'd0) ? 3'(color_n - 4'd1) : CURSOR_COLOR - 3'd1;
        end else if (press_right && !press_left) begin
            cursor_d = ({1'b0, CURSOR_COLOR} == color_n - 4'd1) ? 3'd0 : CURSOR_COLOR + 3'd1;
        end
    end

    assign OUT_OF_MOVES = (MOVE_COUNT >= 6'(MAX_MOVES));
    assign BUSY         = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        color_sel_d = COLOR_SELECTED;
        move_d      = MOVE_COUNT;
        active_d    = GAME_ACTIVE;
        if (press_new && state_q != StIdle) begin
            pending_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (press_new || pending_q) begin
                    state_d   = StNgReq;
                    pending_d = 1'b0;
                end else if (press_sel && GAME_ACTIVE && !OUT_OF_MOVES) begin
                    color_sel_d = CURSOR_COLOR;
                    state_d     = StSelReq;
                end
            end
            StNgReq: begin
                if (STARTED_GAME) begin
                    state_d  = StNgRel;
                    move_d   = '0;
                    active_d = 1'b1;
                end
            end
            StNgRel: begin
                if (!STARTED_GAME) begin
                    state_d = StIdle;
                end
            end
            StSelReq: begin
                if (CHANGING_COLOR) begin
                    state_d = StSelWait;
                end
            end
            StSelWait: begin
                if (!CHANGING_COLOR) begin
                    state_d = StIdle;
                    if (MOVE_COUNT != 6'd63) begin
                        move_d = MOVE_COUNT + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Request lines follow the next state so they are registered yet never lag it.
        sel_sig_d = (state_d == StSelReq);
        start_d   = (state_d == StNgReq);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q        <= StIdle;
            pending_q      <= 1'b0;
            CURSOR_COLOR   <= '0;
            COLOR_SELECTED <= '0;
            COLOR_SEL_SIG  <= 1'b0;
            START_NEW_GAME <= 1'b0;
            MOVE_COUNT     <= '0;
            GAME_ACTIVE    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            CURSOR_COLOR   <= cursor_d;
            COLOR_SELECTED <= color_sel_d;
            COLOR_SEL_SIG  <= sel_sig_d;
            START_NEW_GAME <= start_d;
            MOVE_COUNT     <= move_d;
            GAME_ACTIVE    <= active_d;
        end
    end

endmodule
